// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding, default widths and the slave memory
// depth that the requester and the memory slave agree on.
package apb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   localparam int MEM_DEPTH = 128;
   localparam int MEM_IDX_W = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles and flags the one that would reach the limit.
// A limit of 0 means the requester waits on PREADY forever.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic PCLK,
   input  logic PRESET,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1
                     : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic          ARMED = (TIMEOUT_CYCLES != 0);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // expired is the cycle whose increment would make the count hit the limit
   assign expired = ARMED && enable && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time from a valid/ready port, driven
// through SETUP/ACCESS with a bounded PREADY wait and a one-cycle response.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic [CNT_W-1:0]  xfer_count,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PRWADDR,
   output logic [DATA_W-1:0] PRWDATA,
   input  logic [DATA_W-1:0] PRDATA1,
   input  logic              PREADY
);

   apb_state_e        state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [CNT_W-1:0]  xfer_count_q, xfer_count_d;

   logic              tmr_clear;
   logic              tmr_en;
   logic              tmr_expired;

   apb_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d      = state_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      rsp_valid_d  = 1'b0;
      rsp_err_d    = rsp_err_q;
      rsp_rdata_d  = rsp_rdata_q;
      xfer_count_d = xfer_count_q;
      tmr_clear    = 1'b0;
      tmr_en       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               pwrite_d  = cmd_write;
               paddr_d   = cmd_addr;
               pwdata_d  = cmd_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            tmr_clear = 1'b1;
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            // a late PREADY on the final allowed cycle still completes
            if (PREADY) begin
               psel_d       = 1'b0;
               penable_d    = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_err_d    = 1'b0;
               rsp_rdata_d  = pwrite_q ? '0 : PRDATA1;
               xfer_count_d = xfer_count_q + CNT_W'(1);
               state_d      = IDLE;
            end else begin
               tmr_en = 1'b1;
               if (tmr_expired) begin
                  psel_d      = 1'b0;
                  penable_d   = 1'b0;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  state_d     = IDLE;
               end
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q      <= IDLE;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_rdata_q  <= '0;
         xfer_count_q <= '0;
      end else begin
         state_q      <= state_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_rdata_q  <= rsp_rdata_d;
         xfer_count_q <= xfer_count_d;
      end
   end

   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q == SETUP) || (state_q == ACCESS);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_err    = rsp_err_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign xfer_count = xfer_count_q;
   assign PSEL       = psel_q;
   assign PENABLE    = penable_q;
   assign PWRITE     = pwrite_q;
   assign PRWADDR    = paddr_q;
   assign PRWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master against a word-memory reference model
// and a simple APB memory slave.
module tb_apb_master;
   import apb_pkg::*;

   localparam int TMO  = 16;
   localparam int CNTW = 3;

   logic            PCLK;
   logic            PRESET;
   logic            cmd_valid;
   logic            cmd_ready;
   logic            cmd_write;
   logic [31:0]     cmd_addr;
   logic [31:0]     cmd_wdata;
   logic            rsp_valid;
   logic [31:0]     rsp_rdata;
   logic            rsp_err;
   logic            busy;
   logic [CNTW-1:0] xfer_count;
   logic            PSEL;
   logic            PENABLE;
   logic            PWRITE;
   logic [31:0]     PRWADDR;
   logic [31:0]     PRWDATA;
   logic [31:0]     PRDATA1;
   logic            PREADY;

   apb_master #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (CNTW)
   ) dut (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .xfer_count (xfer_count),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PRWADDR    (PRWADDR),
      .PRWDATA    (PRWDATA),
      .PRDATA1    (PRDATA1),
      .PREADY     (PREADY)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // slave memory, written only through the bus
   logic [31:0] slave_mem [MEM_DEPTH];
   // reference memory, updated only from completed commands
   logic [31:0] model_mem [MEM_DEPTH];
   int          model_cnt;
   logic [31:0] last_rd;
   logic        last_err;

   int tests;
   int fails;

   assign PRDATA1 = slave_mem[PRWADDR[MEM_IDX_W-1:0]];

   always @(posedge PCLK) begin
      if (PSEL && PENABLE && PREADY && PWRITE)
         slave_mem[PRWADDR[MEM_IDX_W-1:0]] <= PRWDATA;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic scramble();
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
   endtask

   // Entered at a negedge with the DUT idle; returns at the negedge of the
   // response cycle, which is again an idle cycle.
   task automatic run_cmd(input logic wr, input int a,
                          input logic [31:0] d, input int waits,
                          input bit hold);
      bit          tmo;
      int          n_acc;
      logic [31:0] exp_rd;
      tmo   = (TMO != 0) && (waits >= TMO);
      n_acc = tmo ? TMO : waits + 1;

      check("idle_ready", cmd_ready, 1);
      check("idle_busy", busy, 0);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = 32'(a);
      cmd_wdata = d;
      PREADY    = 1'($urandom);

      @(negedge PCLK);
      check("setup_psel", PSEL, 1);
      check("setup_pen", PENABLE, 0);
      check("setup_pwrite", PWRITE, wr);
      check("setup_addr", PRWADDR, 32'(a));
      check("setup_wdata", PRWDATA, d);
      check("setup_ready", cmd_ready, 0);
      check("setup_busy", busy, 1);
      check("rsp_pulse_end", rsp_valid, 0);
      check("rsp_rd_hold", rsp_rdata, last_rd);
      check("rsp_err_hold", rsp_err, last_err);
      if (hold) scramble();
      else cmd_valid = 1'b0;
      PREADY = 1'($urandom);

      for (int k = 0; k < n_acc; k++) begin
         @(negedge PCLK);
         check("acc_psel", PSEL, 1);
         check("acc_pen", PENABLE, 1);
         check("acc_addr", PRWADDR, 32'(a));
         check("acc_wdata", PRWDATA, d);
         check("acc_norsp", rsp_valid, 0);
         PREADY = (k == waits);
         if (hold) scramble();
      end

      @(negedge PCLK);
      PREADY = 1'($urandom);
      if (!tmo) begin
         model_cnt = (model_cnt + 1) % (1 << CNTW);
         if (wr) model_mem[a] = d;
      end
      exp_rd = (tmo || wr) ? 32'h0 : model_mem[a];
      check("rsp_valid", rsp_valid, 1);
      check("rsp_err", rsp_err, tmo);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("end_psel", PSEL, 0);
      check("end_pen", PENABLE, 0);
      check("end_addr_kept", PRWADDR, 32'(a));
      check("xfer_count", xfer_count, 32'(model_cnt));
      last_rd  = exp_rd;
      last_err = tmo;
   endtask

   int          r;
   int          w;
   logic [31:0] v;

   initial begin
      tests     = 0;
      fails     = 0;
      model_cnt = 0;
      last_rd   = 32'h0;
      last_err  = 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
         v            = $urandom;
         slave_mem[i] = v;
         model_mem[i] = v;
      end
      PRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0;
      cmd_wdata = 32'h0;
      PREADY    = 1'b0;

      repeat (3) @(negedge PCLK);
      check("rst_psel", PSEL, 0);
      check("rst_pen", PENABLE, 0);
      check("rst_pwrite", PWRITE, 0);
      check("rst_addr", PRWADDR, 0);
      check("rst_wdata", PRWDATA, 0);
      check("rst_rspv", rsp_valid, 0);
      check("rst_rspe", rsp_err, 0);
      check("rst_rspd", rsp_rdata, 0);
      check("rst_cnt", xfer_count, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      PRESET = 1'b0;
      @(negedge PCLK);

      run_cmd(1'b1, 5, 32'hDEADBEEF, 0, 1'b0);
      run_cmd(1'b0, 5, 32'h0, 0, 1'b0);
      check("readback", rsp_rdata, 32'hDEADBEEF);
      run_cmd(1'b0, 5, 32'h0, 4, 1'b0);
      run_cmd(1'b1, 7, 32'h12345678, TMO, 1'b0);
      run_cmd(1'b0, 7, 32'h0, TMO - 1, 1'b0);
      run_cmd(1'b1, 9, 32'hA5A5A5A5, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         w = (r < 6) ? (r % 4) : (r == 6) ? TMO - 1
           : (r == 7) ? TMO : (r == 8) ? TMO + 3 : 1;
         run_cmd(1'($urandom), $urandom_range(0, MEM_DEPTH - 1),
                 $urandom, w, 1'($urandom));
      end

      // reset in the middle of a waiting write
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'd9;
      cmd_wdata = 32'hCAFEF00D;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      PREADY    = 1'b0;
      repeat (2) @(negedge PCLK);
      check("pre_rst_pen", PENABLE, 1);
      #2 PRESET = 1'b1;
      #1;
      check("mid_rst_psel", PSEL, 0);
      check("mid_rst_pen", PENABLE, 0);
      check("mid_rst_cnt", xfer_count, 0);
      check("mid_rst_rspv", rsp_valid, 0);
      check("mid_rst_ready", cmd_ready, 1);
      model_cnt = 0;
      last_rd   = 32'h0;
      last_err  = 1'b0;
      @(negedge PCLK);
      PRESET = 1'b0;
      repeat (2) begin
         @(negedge PCLK);
         check("post_rst_norsp", rsp_valid, 0);
      end
      run_cmd(1'b0, 9, 32'h0, 0, 1'b0);

      // back-to-back with the request held; counter wraps
      model_cnt = 0;
      PRESET    = 1'b1;
      @(negedge PCLK);
      PRESET   = 1'b0;
      last_rd  = 32'h0;
      last_err = 1'b0;
      @(negedge PCLK);
      for (int n = 0; n < 10; n++)
         run_cmd(1'(n % 2), $urandom_range(0, MEM_DEPTH - 1),
                 $urandom, 0, 1'b1);
      cmd_valid = 1'b0;
      check("b2b_cnt", xfer_count, 2);
      @(negedge PCLK);
      check("b2b_idle_norsp", rsp_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that drives the PCLK-domain peripheral bus toward the existing APB memory slave (128 x 32-bit word memory, word-indexed by PRWADDR).
- Accepts single read/write commands from a local valid/ready command port and runs the APB SETUP/ACCESS sequence.
- Waits for PREADY, bounded by a timeout, then returns a one-cycle response pulse carrying read data or an error flag.
- Sits between the testbench/CPU-side command source and the slave.

Parameters:
- ADDR_W, 32: width of PRWADDR and cmd_addr; the word index is passed through unmodified.
- DATA_W, 32: width of PRWDATA, PRDATA1, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.
- CNT_W, 16: width of the completed-transfer counter.

Ports:
- PCLK  input  1  bus clock; all state changes on the rising edge.
- PRESET  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; the command is accepted on cmd_valid&cmd_ready.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_W  target word address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  1  valid with rsp_valid; 1 = timeout abort.
- busy  output  1  high in SETUP or ACCESS.
- xfer_count  output  CNT_W  count of successful transfers; wraps at 2^CNT_W.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PRWADDR  output  ADDR_W  APB address.
- PRWDATA  output  DATA_W  APB write data.
- PRDATA1  input  DATA_W  APB read data from the slave.
- PREADY  input  1  slave ready.

Behaviour:
- Reset values (asynchronous on PRESET):
  - state=IDLE.
  - PSEL, PENABLE, PWRITE = 0; PRWADDR, PRWDATA = 0.
  - rsp_valid, rsp_err = 0; rsp_rdata = 0.
  - xfer_count = 0; wait counter = 0.
- All APB outputs are registered; cmd_ready and busy decode from the state register only.

State machine (IDLE, SETUP, ACCESS):
- IDLE: PSEL=0, PENABLE=0, cmd_ready=1.
  - On handshake: latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PRWADDR and PRWDATA.
  - Go to SETUP with PSEL=1 and PENABLE=0 visible in the next cycle.
- SETUP: exactly one cycle; go to ACCESS (PSEL=1, PENABLE=1). Clear the wait counter.
- ACCESS, sampled each rising edge:
  - PREADY=1: go to IDLE with PSEL=0, PENABLE=0.
    - Pulse rsp_valid=1 and rsp_err=0 in the following cycle.
    - rsp_rdata = PRDATA1 sampled at the same edge if the transfer is a read; 0 if a write.
    - xfer_count += 1.
  - PREADY=0: increment the wait counter.
    - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: go to IDLE with PSEL=0, PENABLE=0.
    - Pulse rsp_valid=1, rsp_err=1, rsp_rdata=0. xfer_count is unchanged.
- Latency: accept edge -> SETUP cycle -> ACCESS cycle. With zero-wait PREADY, rsp_valid is high in the 3rd cycle after the accept edge. Each wait state adds 1 cycle.
- PWRITE, PRWADDR and PRWDATA hold stable from SETUP through the last ACCESS cycle. They keep their last value in IDLE; no glitch to 0.
- rsp_valid is high for exactly one cycle per accepted command. rsp_rdata and rsp_err hold their last value afterwards.
- cmd_valid outside IDLE is ignored; the source must hold it. Minimum spacing between back-to-back commands is 3 cycles (IDLE re-entered for 1 cycle).
- PREADY while in IDLE or SETUP is ignored.
- PRESET asserted mid-transfer:
  - The bus drops immediately (PSEL=0, PENABLE=0).
  - The in-flight command is discarded with no rsp_valid.
  - xfer_count is cleared.
- xfer_count wraps from 2^CNT_W-1 to 0 without any flag.

Decomposition:
- Shared package apb_pkg:
  - state enum (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2).
  - default ADDR_W/DATA_W constants.
  - APB slave memory depth constant (128), shared with the slave.
- One sub-module apb_wait_timer:
  - clear/enable inputs, TIMEOUT_CYCLES parameter, `expired` output.
  - Keeps the timeout counter and its disable-at-0 logic out of the FSM.

Test Plan:
- Single write: cmd write addr=5 data=0xDEADBEEF, slave PREADY=1 in ACCESS -> PSEL 1 for 2 cycles, PENABLE 1 in 2nd only. rsp_valid at +3 cycles, rsp_err=0, rsp_rdata=0, xfer_count=1.
- Read-back: write addr=5 0xDEADBEEF then read addr=5 -> rsp_rdata=0xDEADBEEF. PRWADDR=5 stable across SETUP/ACCESS; xfer_count=2.
- Wait states: read with PREADY held 0 for 4 ACCESS cycles, then 1 -> rsp_valid at +7 cycles; PENABLE high for 5 cycles; rsp_err=0.
- Timeout: TIMEOUT_CYCLES=16, PREADY stuck 0 -> abort after 16 ACCESS wait cycles. rsp_valid=1, rsp_err=1, rsp_rdata=0; xfer_count unchanged; next command accepted normally.
- Reset mid-ACCESS: assert PRESET during ACCESS of a write -> PSEL/PENABLE go 0 asynchronously. No rsp_valid; xfer_count=0; cmd_ready=1 after release.
- Back-to-back plus wrap: 10 cmds with cmd_valid held high, CNT_W=3 -> one accept per 3 cycles, exactly 10 rsp_valid pulses, xfer_count ends at 2.
